// File: rtl/nmea_rmc_tx.sv
// NMEA RMC sentence serializer: "$GNRMC,hhmmss.00,<status>*CS\r\n" streamed one
// ASCII byte at a time over a valid/ready handshake to a UART transmitter.
module nmea_rmc_tx #(
  parameter logic [7:0] STATUS_CHAR = 8'h41
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [23:0] time_bcd,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        done
);

  // state | meaning
  // IDLE  | waiting for start, outputs quiet
  // BODY  | sending "$" through "*" (byte index 0..18)
  // CKH   | sending checksum high nibble as hex ASCII
  // CKL   | sending checksum low nibble as hex ASCII
  // CR    | sending 8'h0D
  // LF    | sending 8'h0A, done pulses after it is accepted
  typedef enum logic [2:0] {IDLE, BODY, CKH, CKL, CR, LF} state_t;

  localparam logic [4:0] LAST_IDX = 5'd18;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [23:0] time_q, time_d;
  logic [7:0]  csum_q, csum_d;
  logic        done_q, done_d;
  logic [3:0]  digit;
  logic [7:0]  body_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    hex_ascii = (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    digit = 4'h0;
    case (idx_q)
      5'd7:    digit = time_q[23:20];
      5'd8:    digit = time_q[19:16];
      5'd9:    digit = time_q[15:12];
      5'd10:   digit = time_q[11:8];
      5'd11:   digit = time_q[7:4];
      5'd12:   digit = time_q[3:0];
      default: digit = 4'h0;
    endcase

    body_byte = 8'h00;
    case (idx_q)
      5'd0:                                    body_byte = 8'h24;
      5'd1:                                    body_byte = 8'h47;
      5'd2:                                    body_byte = 8'h4E;
      5'd3:                                    body_byte = 8'h52;
      5'd4:                                    body_byte = 8'h4D;
      5'd5:                                    body_byte = 8'h43;
      5'd6:                                    body_byte = 8'h2C;
      5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12:   body_byte = 8'h30 + {4'h0, digit};
      5'd13:                                   body_byte = 8'h2E;
      5'd14, 5'd15:                            body_byte = 8'h30;
      5'd16:                                   body_byte = 8'h2C;
      5'd17:                                   body_byte = STATUS_CHAR;
      5'd18:                                   body_byte = 8'h2A;
      default:                                 body_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    time_d   = time_q;
    csum_d   = csum_q;
    done_d   = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BODY;
          idx_d   = 5'd0;
          time_d  = time_bcd;
          csum_d  = 8'h00;
        end
      end
      BODY: begin
        tx_valid = 1'b1;
        tx_data  = body_byte;
        if (tx_ready) begin
          // "$" and "*" are excluded from the checksum
          if (idx_q != 5'd0 && idx_q != LAST_IDX) csum_d = csum_q ^ body_byte;
          if (idx_q == LAST_IDX) state_d = CKH;
          else                   idx_d   = idx_q + 5'd1;
        end
      end
      CKH: begin
        tx_valid = 1'b1;
        tx_data  = hex_ascii(csum_q[7:4]);
        if (tx_ready) state_d = CKL;
      end
      CKL: begin
        tx_valid = 1'b1;
        tx_data  = hex_ascii(csum_q[3:0]);
        if (tx_ready) state_d = CR;
      end
      CR: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
        if (tx_ready) state_d = LF;
      end
      LF: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
        if (tx_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      time_q  <= 24'h000000;
      csum_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      time_q  <= time_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_nmea_rmc_tx.sv
// Scoreboard bench for nmea_rmc_tx: expected sentences are built from the time
// value at start acceptance and popped as the DUT hands bytes over.
module tb_nmea_rmc_tx;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] time_bcd = 24'h0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;

  nmea_rmc_tx #(.STATUS_CHAR(8'h41)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .time_bcd  (time_bcd),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 sys_clk = ~sys_clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         done_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx[$];
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic       exp_dollar = 1'b0;
  logic       exp_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  task automatic push_sentence(input logic [23:0] t);
    logic [7:0] s[$];
    logic [7:0] cs;
    logic [3:0] d;
    s = {8'h24, 8'h47, 8'h4E, 8'h52, 8'h4D, 8'h43, 8'h2C};
    for (int k = 0; k < 6; k++) begin
      d = t[23 - 4*k -: 4];
      s.push_back(8'h30 + {4'h0, d});
    end
    s.push_back(8'h2E); s.push_back(8'h30); s.push_back(8'h30); s.push_back(8'h2C);
    s.push_back(8'h41); s.push_back(8'h2A);
    cs = 8'h00;
    for (int k = 1; k < 18; k++) cs = cs ^ s[k];
    s.push_back(hexc(cs[7:4])); s.push_back(hexc(cs[3:0]));
    s.push_back(8'h0D); s.push_back(8'h0A);
    foreach (s[k]) exp_q.push_back(s[k]);
  endtask

  // One cycle: drive inputs, check what the DUT shows before the next rising edge.
  task automatic tick(input logic s, input logic r);
    logic       nd;
    logic       ndone;
    logic [7:0] e;
    nd = 1'b0;
    ndone = 1'b0;
    start = s;
    tx_ready = r;
    if (s && exp_q.size() == 0) begin
      push_sentence(time_bcd);
      acc_cyc = cyc;
      nd = 1'b1;
    end
    chk("done", {31'd0, done}, {31'd0, exp_done});
    if (done) done_cyc = cyc;
    if (exp_done) chk("busy_in_done", {31'd0, busy}, 0);
    if (exp_dollar) begin
      chk("first_valid", {31'd0, tx_valid}, 1);
      chk("first_dollar", {24'd0, tx_data}, 32'h24);
      chk("first_busy", {31'd0, busy}, 1);
    end
    if (hold_pend) begin
      chk("hold_valid", {31'd0, tx_valid}, 1);
      chk("hold_data", {24'd0, tx_data}, {24'd0, hold_data});
    end
    hold_pend = tx_valid && !r;
    hold_data = tx_data;
    if (tx_valid && r) begin
      chk("byte_expected", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("byte", {24'd0, tx_data}, {24'd0, e});
        rx.push_back(tx_data);
        if (exp_q.size() == 0) ndone = 1'b1;
      end
    end
    exp_dollar = nd;
    exp_done = ndone;
    cyc++;
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic run_body(input logic rnd);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 600) begin
      tick(1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      g++;
    end
    chk("timeout", exp_q.size(), 0);
  endtask

  task automatic check_cs(input string tag, input logic [7:0] hi, input logic [7:0] lo);
    chk({tag, "_len"}, rx.size(), 23);
    if (rx.size() == 23) begin
      chk({tag, "_ckh"}, {24'd0, rx[19]}, {24'd0, hi});
      chk({tag, "_ckl"}, {24'd0, rx[20]}, {24'd0, lo});
    end
  endtask

  initial begin
    tx_ready = 1'b1;
    #1;
    chk("rst_valid", {31'd0, tx_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_data", {24'd0, tx_data}, 0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick(1'b0, 1'b1);

    // nominal sentence, ready always high
    rx.delete();
    time_bcd = 24'h123456;
    tick(1'b1, 1'b1);
    run_body(1'b0);
    tick(1'b0, 1'b1);
    chk("latency_done", done_cyc - acc_cyc, 24);
    check_cs("t123456", 8'h33, 8'h44);
    if (rx.size() == 23) begin
      chk("t1_cr", {24'd0, rx[21]}, 32'h0D);
      chk("t1_lf", {24'd0, rx[22]}, 32'h0A);
    end

    // all-zero time
    rx.delete();
    time_bcd = 24'h000000;
    tick(1'b1, 1'b1);
    run_body(1'b0);
    tick(1'b0, 1'b1);
    check_cs("t000000", 8'h33, 8'h41);

    // random backpressure
    rx.delete();
    time_bcd = 24'h123456;
    tick(1'b1, 1'b1);
    run_body(1'b1);
    tick(1'b0, 1'b1);
    check_cs("rnd_ready", 8'h33, 8'h44);

    // start re-pulsed mid-sentence with new time must be ignored
    rx.delete();
    time_bcd = 24'h123456;
    tick(1'b1, 1'b1);
    for (int g = 0; g < 40 && rx.size() < 10; g++) tick(1'b0, 1'b1);
    time_bcd = 24'h235959;
    tick(1'b1, 1'b1);
    run_body(1'b0);
    tick(1'b0, 1'b1);
    check_cs("restart", 8'h33, 8'h44);
    if (rx.size() == 23)
      for (int k = 0; k < 6; k++) chk("restart_digit", {24'd0, rx[7+k]}, 32'h31 + k);
    for (int g = 0; g < 30; g++) begin
      chk("no_second", {31'd0, tx_valid}, 0);
      tick(1'b0, 1'b1);
    end

    // reset in the middle of a sentence
    rx.delete();
    time_bcd = 24'h123456;
    tick(1'b1, 1'b1);
    for (int g = 0; g < 40 && rx.size() < 12; g++) tick(1'b0, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, tx_valid}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_data", {24'd0, tx_data}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    exp_q.delete();
    hold_pend = 1'b0;
    exp_dollar = 1'b0;
    exp_done = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int g = 0; g < 3; g++) begin
      chk("post_rst_idle", {31'd0, tx_valid}, 0);
      tick(1'b0, 1'b1);
    end
    rx.delete();
    tick(1'b1, 1'b1);
    run_body(1'b0);
    tick(1'b0, 1'b1);
    check_cs("after_rst", 8'h33, 8'h44);
    if (rx.size() != 0) chk("after_rst_first", {24'd0, rx[0]}, 32'h24);

    // back-to-back: start issued in the done cycle
    rx.delete();
    time_bcd = 24'h123456;
    tick(1'b1, 1'b1);
    run_body(1'b0);
    time_bcd = 24'h000000;
    tick(1'b1, 1'b1);
    chk("b2b_accept_in_done", {31'd0, exp_dollar}, 1);
    run_body(1'b0);
    tick(1'b0, 1'b1);
    chk("b2b_len", rx.size(), 46);
    if (rx.size() == 46) begin
      chk("b2b_dollar", {24'd0, rx[23]}, 32'h24);
      chk("b2b_ckh", {24'd0, rx[42]}, 32'h33);
      chk("b2b_ckl", {24'd0, rx[43]}, 32'h41);
    end
    tick(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
